// File: rtl/exc_detect_unit_if.sv
// Signal bundle between the MEM stage / CP0 and the exception detector.
// The slave side is the detector; the master side drives MEM-stage state.
interface exc_detect_unit_if;
  logic        valid_m;
  logic [31:0] pc_m;
  logic        bd_m;
  logic        mem_rd_m;
  logic        mem_wr_m;
  logic [1:0]  mem_size_m;
  logic [31:0] mem_addr_m;
  logic        ri_m;
  logic        sys_m;
  logic        brk_m;
  logic        ovf_m;
  logic        eret_m;
  logic        int_pending;
  logic        status_exl;
  logic [31:0] epc_q;
  logic        redirect_ack;

  logic        mem_kill;
  logic        r_p;
  logic        addr_err;
  logic [31:0] badvaddr_p;
  logic [4:0]  exc_code;
  logic        bd;
  logic [31:0] epc_p;
  logic        epc_we;
  logic        exl_set;
  logic        exl_clr;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport slave (
    input  valid_m, pc_m, bd_m, mem_rd_m, mem_wr_m, mem_size_m, mem_addr_m,
           ri_m, sys_m, brk_m, ovf_m, eret_m, int_pending, status_exl, epc_q,
           redirect_ack,
    output mem_kill, r_p, addr_err, badvaddr_p, exc_code, bd, epc_p, epc_we,
           exl_set, exl_clr, flush, redirect_valid, redirect_pc
  );

  modport master (
    output valid_m, pc_m, bd_m, mem_rd_m, mem_wr_m, mem_size_m, mem_addr_m,
           ri_m, sys_m, brk_m, ovf_m, eret_m, int_pending, status_exl, epc_q,
           redirect_ack,
    input  mem_kill, r_p, addr_err, badvaddr_p, exc_code, bd, epc_p, epc_we,
           exl_set, exl_clr, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exc_detect_unit.sv
// MEM-stage exception detector: resolves MIPS exception priority, pulses the
// CP0 update strobes, then sequences a pipeline flush and a fetch redirect.
module exc_detect_unit #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  exc_detect_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TAKE,
    S_DRAIN,
    S_REDIRECT
  } state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic        r_eret_mode;
  logic        r_addr_err;
  logic        r_epc_en;
  logic        r_bd;
  logic [4:0]  r_code;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic [31:0] r_redirect_pc;

  logic        w_int;
  logic        w_fetch_ade;
  logic        w_data_mis;
  logic        w_exc;
  logic        w_ade;
  logic [4:0]  w_code;
  logic [31:0] w_badvaddr;
  logic        w_idle_valid;
  logic        w_exc_take;
  logic        w_eret_take;

  assign w_int       = bus.int_pending && !bus.status_exl;
  assign w_fetch_ade = (bus.pc_m[1:0] != 2'b00);

  // Size 2'b11 falls into the word rule.
  always_comb begin
    w_data_mis = 1'b0;
    if (bus.mem_rd_m || bus.mem_wr_m) begin
      case (bus.mem_size_m)
        2'b00:   w_data_mis = 1'b0;
        2'b01:   w_data_mis = bus.mem_addr_m[0];
        default: w_data_mis = |bus.mem_addr_m[1:0];
      endcase
    end
  end

  always_comb begin
    w_exc      = 1'b1;
    w_ade      = 1'b0;
    w_code     = 5'd0;
    w_badvaddr = bus.mem_addr_m;
    if (w_int) begin
      w_code = 5'd0;
    end else if (w_fetch_ade) begin
      w_code     = 5'd4;
      w_ade      = 1'b1;
      w_badvaddr = bus.pc_m;
    end else if (bus.ri_m) begin
      w_code = 5'd10;
    end else if (bus.sys_m) begin
      w_code = 5'd8;
    end else if (bus.brk_m) begin
      w_code = 5'd9;
    end else if (bus.ovf_m) begin
      w_code = 5'd12;
    end else if (w_data_mis) begin
      w_code = bus.mem_rd_m ? 5'd4 : 5'd5;
      w_ade  = 1'b1;
    end else begin
      w_exc = 1'b0;
    end
  end

  assign w_idle_valid = (r_state == S_IDLE) && bus.valid_m;
  assign w_exc_take   = w_idle_valid && w_exc;
  assign w_eret_take  = w_idle_valid && bus.eret_m && !w_exc;
  assign bus.mem_kill = !rst && (w_exc_take || w_eret_take);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_exc_take || w_eret_take) w_state_next = S_TAKE;
      end
      S_TAKE: begin
        w_state_next = S_DRAIN;
        w_cnt_next   = 4'(FLUSH_CYCLES);
      end
      S_DRAIN: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_state_next = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (bus.redirect_ack) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_eret_mode   <= 1'b0;
      r_addr_err    <= 1'b0;
      r_epc_en      <= 1'b0;
      r_bd          <= 1'b0;
      r_code        <= 5'd0;
      r_epc         <= 32'd0;
      r_badvaddr    <= 32'd0;
      r_redirect_pc <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_exc_take) begin
        r_eret_mode   <= 1'b0;
        r_addr_err    <= w_ade;
        r_epc_en      <= !bus.status_exl;
        r_bd          <= bus.bd_m;
        r_code        <= w_code;
        r_epc         <= bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m;
        r_redirect_pc <= EXC_VECTOR;
        // BadVAddr only tracks address errors; other causes leave it alone.
        if (w_ade) r_badvaddr <= w_badvaddr;
      end else if (w_eret_take) begin
        r_eret_mode   <= 1'b1;
        r_redirect_pc <= bus.epc_q;
      end
    end
  end

  assign bus.r_p            = (r_state == S_TAKE) && !r_eret_mode;
  assign bus.exl_set        = (r_state == S_TAKE) && !r_eret_mode;
  assign bus.addr_err       = (r_state == S_TAKE) && !r_eret_mode && r_addr_err;
  assign bus.epc_we         = (r_state == S_TAKE) && !r_eret_mode && r_epc_en;
  assign bus.exl_clr        = (r_state == S_TAKE) && r_eret_mode;
  assign bus.flush          = (r_state == S_TAKE) || (r_state == S_DRAIN);
  assign bus.redirect_valid = (r_state == S_REDIRECT);
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.exc_code       = r_code;
  assign bus.bd             = r_bd;
  assign bus.epc_p          = r_epc;
  assign bus.badvaddr_p     = r_badvaddr;

endmodule

// File: tb/tb_exc_detect_unit.sv
// Scoreboard bench for exc_detect_unit: expected CP0 updates are queued when
// an instruction is presented and popped in the cycle the strobes fire.
module tb_exc_detect_unit;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exc_detect_unit_if bus();

  exc_detect_unit #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ctrl = {r_p, addr_err, exl_set, exl_clr, epc_we, flush}
  typedef struct packed {
    logic [5:0]  ctrl;
    logic [4:0]  code;
    logic        bdv;
    logic [31:0] epc;
    logic [31:0] badv;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic exp_t mk(logic [5:0] c, logic [4:0] code, logic b,
                              logic [31:0] epc, logic [31:0] badv, logic [31:0] rpc);
    mk = '{ctrl: c, code: code, bdv: b, epc: epc, badv: badv, rpc: rpc};
  endfunction

  task automatic idle_inputs();
    bus.valid_m = 0; bus.pc_m = 0; bus.bd_m = 0; bus.mem_rd_m = 0; bus.mem_wr_m = 0;
    bus.mem_size_m = 2'b10; bus.mem_addr_m = 0; bus.ri_m = 0; bus.sys_m = 0;
    bus.brk_m = 0; bus.ovf_m = 0; bus.eret_m = 0; bus.int_pending = 0;
    bus.status_exl = 0; bus.epc_q = 0; bus.redirect_ack = 0;
  endtask

  task automatic observe_take(output bit got, output exp_t e, output exp_t o);
    @(negedge clk);
    got = (sb.size() != 0);
    e = '0;
    if (got) e = sb.pop_front();
    o = {bus.r_p, bus.addr_err, bus.exl_set, bus.exl_clr, bus.epc_we, bus.flush,
         bus.exc_code, bus.bd, bus.epc_p, bus.badvaddr_p, bus.redirect_pc};
  endtask

  task automatic wait_redirect(input bit do_ack, output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.redirect_valid) begin ok = 1; break; end
    end
    if (ok && do_ack) begin
      bus.redirect_ack = 1;
      @(posedge clk); #1;
      bus.redirect_ack = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({bus.mem_kill, bus.r_p, bus.addr_err, bus.exl_set, bus.exl_clr, bus.epc_we, bus.flush,
         bus.redirect_valid, bus.exc_code, bus.bd, bus.epc_p, bus.badvaddr_p, bus.redirect_pc} !== '0)
      $display("FAIL reset_outputs act epc=%h badv=%h rpc=%h code=%0d flush=%b rv=%b exp all zero",
               bus.epc_p, bus.badvaddr_p, bus.redirect_pc, bus.exc_code, bus.flush, bus.redirect_valid);
    else n_pass++;
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_load_adel();
    bit got; exp_t e, o;
    @(posedge clk); #1;
    bus.valid_m = 1; bus.pc_m = 32'h8000_0010; bus.mem_rd_m = 1; bus.mem_size_m = 2'b10;
    bus.mem_addr_m = 32'h0000_000F;
    sb.push_back(mk(6'b111011, 5'd4, 1'b0, 32'h8000_0010, 32'h0000_000F, VEC));
    @(negedge clk);
    n_total++;
    if (bus.mem_kill !== 1'b1) $display("FAIL load_mem_kill act=%b exp=1", bus.mem_kill); else n_pass++;
    @(posedge clk); #1 idle_inputs();
    observe_take(got, e, o);
    n_total++;
    if (!got || o !== e) $display("FAIL load_take act=%h exp=%h", o, e); else n_pass++;
    // A syscall offered during drain must be ignored.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      bus.valid_m = 1; bus.sys_m = 1;
      @(negedge clk);
      n_total++;
      if ({bus.flush, bus.r_p, bus.mem_kill, bus.redirect_valid} !== 4'b1000)
        $display("FAIL load_drain%0d act flush/rp/kill/rv=%b%b%b%b exp=1000", i,
                 bus.flush, bus.r_p, bus.mem_kill, bus.redirect_valid);
      else n_pass++;
    end
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    n_total++;
    if ({bus.redirect_valid, bus.flush, bus.redirect_pc} !== {1'b1, 1'b0, VEC})
      $display("FAIL load_redirect act rv=%b flush=%b rpc=%h exp rv=1 flush=0 rpc=%h",
               bus.redirect_valid, bus.flush, bus.redirect_pc, VEC);
    else n_pass++;
    bus.redirect_ack = 1;
    @(posedge clk); #1 bus.redirect_ack = 0;
    @(negedge clk);
    n_total++;
    if ({bus.redirect_valid, bus.flush, bus.r_p} !== 3'b000)
      $display("FAIL load_after_ack act rv/flush/rp=%b%b%b exp=000", bus.redirect_valid, bus.flush, bus.r_p);
    else n_pass++;
  endtask

  task automatic test_store_ades();
    bit got, ok; exp_t e, o;
    @(posedge clk); #1;
    bus.valid_m = 1; bus.pc_m = 32'h8000_0104; bus.bd_m = 1; bus.mem_wr_m = 1;
    bus.mem_size_m = 2'b01; bus.mem_addr_m = 32'h0000_1001;
    sb.push_back(mk(6'b111011, 5'd5, 1'b1, 32'h8000_0100, 32'h0000_1001, VEC));
    @(negedge clk);
    n_total++;
    if (bus.mem_kill !== 1'b1) $display("FAIL store_mem_kill act=%b exp=1", bus.mem_kill); else n_pass++;
    @(posedge clk); #1 idle_inputs();
    observe_take(got, e, o);
    n_total++;
    if (!got || o !== e) $display("FAIL store_take act=%h exp=%h", o, e); else n_pass++;
    wait_redirect(1'b1, ok);
    n_total++;
    if (!ok) $display("FAIL store_redirect act=timeout exp=redirect_valid"); else n_pass++;
  endtask

  task automatic test_fetch_adel();
    bit got, ok; exp_t e, o;
    @(posedge clk); #1;
    bus.valid_m = 1; bus.pc_m = 32'h8000_0002; bus.ri_m = 1; bus.mem_rd_m = 1;
    bus.mem_size_m = 2'b10; bus.mem_addr_m = 32'h0000_0003;
    sb.push_back(mk(6'b111011, 5'd4, 1'b0, 32'h8000_0002, 32'h8000_0002, VEC));
    @(posedge clk); #1 idle_inputs();
    observe_take(got, e, o);
    n_total++;
    if (!got || o !== e) $display("FAIL fetch_take act=%h exp=%h", o, e); else n_pass++;
    wait_redirect(1'b1, ok);
    n_total++;
    if (!ok) $display("FAIL fetch_redirect act=timeout exp=redirect_valid"); else n_pass++;
  endtask

  task automatic test_syscall();
    bit got, ok; exp_t e, o;
    @(posedge clk); #1;
    bus.valid_m = 1; bus.pc_m = 32'h8000_0300; bus.sys_m = 1;
    sb.push_back(mk(6'b101011, 5'd8, 1'b0, 32'h8000_0300, 32'h8000_0002, VEC));
    @(posedge clk); #1 idle_inputs();
    observe_take(got, e, o);
    n_total++;
    if (!got || o !== e) $display("FAIL sys_take act=%h exp=%h", o, e); else n_pass++;
    wait_redirect(1'b1, ok);
    n_total++;
    if (!ok) $display("FAIL sys_redirect act=timeout exp=redirect_valid"); else n_pass++;
  endtask

  task automatic test_int_masked();
    @(posedge clk); #1;
    bus.valid_m = 1; bus.pc_m = 32'h8000_0400; bus.int_pending = 1; bus.status_exl = 1;
    @(negedge clk);
    n_total++;
    if (bus.mem_kill !== 1'b0) $display("FAIL int_masked_kill act=%b exp=0", bus.mem_kill); else n_pass++;
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    n_total++;
    if ({bus.r_p, bus.flush, bus.exl_set, bus.exl_clr} !== 4'b0000)
      $display("FAIL int_masked_take act rp/flush/set/clr=%b%b%b%b exp=0000",
               bus.r_p, bus.flush, bus.exl_set, bus.exl_clr);
    else n_pass++;
  endtask

  task automatic test_priority();
    bit got, ok; exp_t e, o;
    @(posedge clk); #1;
    bus.valid_m = 1; bus.pc_m = 32'h8000_0401; bus.int_pending = 1; bus.sys_m = 1;
    bus.eret_m = 1; bus.mem_rd_m = 1; bus.mem_addr_m = 32'h0000_0001;
    sb.push_back(mk(6'b101011, 5'd0, 1'b0, 32'h8000_0401, 32'h8000_0002, VEC));
    @(posedge clk); #1 idle_inputs();
    observe_take(got, e, o);
    n_total++;
    if (!got || o !== e) $display("FAIL prio_int_take act=%h exp=%h", o, e); else n_pass++;
    wait_redirect(1'b1, ok);
    n_total++;
    if (!ok) $display("FAIL prio_redirect act=timeout exp=redirect_valid"); else n_pass++;
  endtask

  task automatic test_exl_epc_wrap();
    bit got, ok; exp_t e, o;
    @(posedge clk); #1;
    bus.valid_m = 1; bus.pc_m = 32'h0000_0000; bus.bd_m = 1; bus.ovf_m = 1; bus.status_exl = 1;
    sb.push_back(mk(6'b101001, 5'd12, 1'b1, 32'hFFFF_FFFC, 32'h8000_0002, VEC));
    @(posedge clk); #1 idle_inputs();
    observe_take(got, e, o);
    n_total++;
    if (!got || o !== e) $display("FAIL exl_ovf_take act=%h exp=%h", o, e); else n_pass++;
    wait_redirect(1'b1, ok);
    n_total++;
    if (!ok) $display("FAIL exl_redirect act=timeout exp=redirect_valid"); else n_pass++;
  endtask

  task automatic test_eret();
    bit got; exp_t e, o;
    @(posedge clk); #1;
    bus.valid_m = 1; bus.pc_m = 32'h8000_0600; bus.eret_m = 1; bus.epc_q = 32'h8000_0200;
    sb.push_back(mk(6'b000101, 5'd12, 1'b1, 32'hFFFF_FFFC, 32'h8000_0002, 32'h8000_0200));
    @(negedge clk);
    n_total++;
    if (bus.mem_kill !== 1'b1) $display("FAIL eret_mem_kill act=%b exp=1", bus.mem_kill); else n_pass++;
    @(posedge clk); #1 idle_inputs();
    observe_take(got, e, o);
    n_total++;
    if (!got || o !== e) $display("FAIL eret_take act=%h exp=%h", o, e); else n_pass++;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_total++;
      if ({bus.redirect_valid, bus.flush, bus.redirect_pc} !== {1'b1, 1'b0, 32'h8000_0200})
        $display("FAIL eret_hold%0d act rv=%b flush=%b rpc=%h exp rv=1 flush=0 rpc=80000200",
                 i, bus.redirect_valid, bus.flush, bus.redirect_pc);
      else n_pass++;
    end
    bus.redirect_ack = 1;
    @(posedge clk); #1 bus.redirect_ack = 0;
    @(negedge clk);
    n_total++;
    if (bus.redirect_valid !== 1'b0) $display("FAIL eret_after_ack act rv=%b exp=0", bus.redirect_valid);
    else n_pass++;
  endtask

  task automatic test_eret_with_exc();
    bit got, ok; exp_t e, o;
    @(posedge clk); #1;
    bus.valid_m = 1; bus.pc_m = 32'h8000_0610; bus.eret_m = 1; bus.sys_m = 1;
    bus.epc_q = 32'h8000_0200;
    sb.push_back(mk(6'b101011, 5'd8, 1'b0, 32'h8000_0610, 32'h8000_0002, VEC));
    @(posedge clk); #1 idle_inputs();
    observe_take(got, e, o);
    n_total++;
    if (!got || o !== e) $display("FAIL eret_exc_take act=%h exp=%h", o, e); else n_pass++;
    wait_redirect(1'b1, ok);
    n_total++;
    if (!ok) $display("FAIL eret_exc_redirect act=timeout exp=redirect_valid"); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit got, ok; exp_t e, o;
    @(posedge clk); #1;
    bus.valid_m = 1; bus.pc_m = 32'h8000_0700; bus.brk_m = 1;
    sb.push_back(mk(6'b101011, 5'd9, 1'b0, 32'h8000_0700, 32'h8000_0002, VEC));
    @(posedge clk); #1 idle_inputs();
    observe_take(got, e, o);
    n_total++;
    if (!got || o !== e) $display("FAIL b2b_brk_take act=%h exp=%h", o, e); else n_pass++;
    wait_redirect(1'b0, ok);
    n_total++;
    if (!ok) $display("FAIL b2b_redirect act=timeout exp=redirect_valid"); else n_pass++;
    // Ack on the first REDIRECT cycle together with the next faulting instruction.
    bus.redirect_ack = 1; bus.valid_m = 1; bus.pc_m = 32'h8000_0704; bus.ri_m = 1;
    #1;
    n_total++;
    if (bus.mem_kill !== 1'b0) $display("FAIL b2b_kill_in_redirect act=%b exp=0", bus.mem_kill); else n_pass++;
    sb.push_back(mk(6'b101011, 5'd10, 1'b0, 32'h8000_0704, 32'h8000_0002, VEC));
    @(posedge clk); #1 bus.redirect_ack = 0;
    @(negedge clk);
    n_total++;
    if ({bus.mem_kill, bus.redirect_valid} !== 2'b10)
      $display("FAIL b2b_kill_idle act kill/rv=%b%b exp=10", bus.mem_kill, bus.redirect_valid);
    else n_pass++;
    @(posedge clk); #1 idle_inputs();
    observe_take(got, e, o);
    n_total++;
    if (!got || o !== e) $display("FAIL b2b_ri_take act=%h exp=%h", o, e); else n_pass++;
    wait_redirect(1'b1, ok);
    n_total++;
    if (!ok) $display("FAIL b2b_ri_redirect act=timeout exp=redirect_valid"); else n_pass++;
  endtask

  task automatic test_reset_drain();
    bit got, seen; exp_t e, o;
    @(posedge clk); #1;
    bus.valid_m = 1; bus.pc_m = 32'h8000_0800; bus.ovf_m = 1;
    sb.push_back(mk(6'b101011, 5'd12, 1'b0, 32'h8000_0800, 32'h8000_0002, VEC));
    @(posedge clk); #1 idle_inputs();
    observe_take(got, e, o);
    n_total++;
    if (!got || o !== e) $display("FAIL rstd_take act=%h exp=%h", o, e); else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.flush !== 1'b1) $display("FAIL rstd_in_drain act flush=%b exp=1", bus.flush); else n_pass++;
    rst = 1;
    @(negedge clk);
    n_total++;
    if ({bus.mem_kill, bus.r_p, bus.addr_err, bus.exl_set, bus.exl_clr, bus.epc_we, bus.flush,
         bus.redirect_valid, bus.exc_code, bus.bd, bus.epc_p, bus.badvaddr_p, bus.redirect_pc} !== '0)
      $display("FAIL rstd_outputs act epc=%h badv=%h rpc=%h code=%0d flush=%b rv=%b exp all zero",
               bus.epc_p, bus.badvaddr_p, bus.redirect_pc, bus.exc_code, bus.flush, bus.redirect_valid);
    else n_pass++;
    rst = 0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.redirect_valid || bus.flush) seen = 1;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL rstd_no_redirect act=activity exp=quiet"); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_adel();
    test_store_ades();
    test_fetch_adel();
    test_syscall();
    test_int_masked();
    test_priority();
    test_exl_epc_wrap();
    test_eret();
    test_eret_with_exc();
    test_back_to_back();
    test_reset_drain();
    n_total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain act=%0d entries exp=0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exc_detect_unit.md
# exc_detect_unit

MEM-stage exception detector and sequencer for the CP0 block. Each cycle it inspects the instruction in MEM and detects instruction-fetch/data address errors and other exceptions. It resolves MIPS exception priority and produces the one-cycle CP0 write strobe (`r_p`), `addr_err` and `badvaddr_p` that feed the BadVAddr register, plus EPC/Cause/Status updates. It then sequences pipeline flush and a fetch redirect handshake.

## Interface
- `EXC_VECTOR`, 32'hBFC0_0380: redirect target for taken exceptions.
- `FLUSH_CYCLES`, 2: cycles `flush` is held after the TAKE cycle (1..15).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `valid_m`  in  1  MEM-stage instruction valid.
- `pc_m`  in  32  PC of MEM instruction.
- `bd_m`  in  1  MEM instruction is in a branch delay slot.
- `mem_rd_m` / `mem_wr_m`  in  1 each  load / store.
- `mem_size_m`  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- `mem_addr_m`  in  32  effective data address.
- `ri_m`, `sys_m`, `brk_m`, `ovf_m`, `eret_m`  in  1 each  reserved instr, syscall, break, overflow, eret.
- `int_pending`  in  1  (Cause.IP & Status.IM) != 0 and Status.IE.
- `status_exl`  in  1  current Status.EXL.
- `epc_q`  in  32  current EPC (eret target).
- `redirect_ack`  in  1  fetch accepted redirect.
- `mem_kill`  out  1  combinational; suppress memory access this cycle.
- `r_p`  out  1  CP0 exception-write strobe (one-cycle pulse).
- `addr_err`  out  1  exception is AdEL/AdES (valid with `r_p`).
- `badvaddr_p`  out  32  faulting virtual address.
- `exc_code`  out  5  Cause.ExcCode.
- `bd`  out  1  Cause.BD value.
- `epc_p`  out  32  EPC value; `epc_we` out 1 EPC write enable.
- `exl_set` / `exl_clr`  out  1 each  Status.EXL set / clear pulses.
- `flush`  out  1  squash IF..MEM.
- `redirect_valid`  out  1; `redirect_pc`  out  32.

## Operation
- States: IDLE, TAKE, DRAIN, REDIRECT. Inputs are ignored outside IDLE.
- Detection in IDLE, only when `valid_m`. Priority, highest first:
  - Int (0): `int_pending & ~status_exl`.
  - Fetch AdEL (4): `pc_m[1:0]!=0`, badvaddr=`pc_m`.
  - RI (10).
  - Sys (8).
  - Bp (9).
  - Ov (12).
  - Data AdEL (4, load) / AdES (5, store), badvaddr=`mem_addr_m`.
- Data misalignment rules: half requires `addr[0]==0`; word requires `addr[1:0]==0`; byte never misaligned.
- `mem_kill`=1 combinationally in the detection cycle for any exception or eret.
- Exception detected: latch code/badvaddr/bd/pc, go to TAKE.
  - `epc_p` = `bd_m` ? `pc_m`-4 : `pc_m` (32-bit wrap).
  - `epc_we` = ~`status_exl`.
- `eret_m` with no exception: go to TAKE in eret mode, with `redirect_pc`=`epc_q` latched at detection.
- TAKE (1 cycle):
  - Exception mode: `r_p`=1, `exl_set`=1, `flush`=1; `addr_err`=1 only for codes 4/5.
  - Eret mode: `exl_clr`=1, `flush`=1; no `r_p`, no `epc_we`.
  - Next state: DRAIN, counter loaded with FLUSH_CYCLES.
- DRAIN: `flush`=1; counter decrements each cycle; go to REDIRECT when the counter reaches 0.
- REDIRECT: `redirect_valid`=1, `redirect_pc` stable (EXC_VECTOR or latched EPC), `flush`=0. Return to IDLE in the cycle `redirect_ack`=1 is sampled.
- `badvaddr_p` updates only on address-error exceptions and otherwise holds its last value.

## Timing
- Reset: state IDLE; all outputs 0, including `badvaddr_p`, `epc_p`, `redirect_pc`, `exc_code`.
- Reset asserted in any state: IDLE the next cycle, no further pulses, `redirect_valid` drops.
- Latency: detection at cycle T. `r_p`/`addr_err`/`exl_set`/`epc_we` assert at T+1 only. `flush` is held T+1..T+1+FLUSH_CYCLES. `redirect_valid` first asserts at T+2+FLUSH_CYCLES.
- `redirect_ack` is ignored outside REDIRECT. `redirect_ack` may already be high on the first REDIRECT cycle; the return to IDLE then takes one cycle.
- Exception and eret in the same instruction: exception wins.
- Back-to-back: a new exception is detected no earlier than the cycle after leaving REDIRECT.

## Test plan
- Word load, `mem_addr_m`=0x0000_000F, `pc_m`=0x8000_0010, bd=0 → `mem_kill` at T. At T+1: `r_p`=1, `addr_err`=1, `exc_code`=4, `badvaddr_p`=0x0000_000F, `epc_p`=0x8000_0010. `flush` T+1..T+3. `redirect_pc`=0xBFC0_0380 at T+4.
- Half store to 0x1001, bd=1, `pc_m`=0x8000_0104 → `exc_code`=5, `epc_p`=0x8000_0100, `bd`=1, `addr_err`=1.
- `pc_m`=0x8000_0002 with `ri_m`=1 and a misaligned load → code 4, `badvaddr_p`=0x8000_0002.
- Syscall → `r_p`=1, `addr_err`=0, `badvaddr_p` unchanged from the previous test. Then `int_pending` with `status_exl`=1 → not taken.
- Eret with `epc_q`=0x8000_0200 → `exl_clr` pulse, no `r_p`, `redirect_pc`=0x8000_0200. Hold `redirect_ack`=0 for 3 cycles: `redirect_valid` stays high with stable `redirect_pc`.
- `rst`=1 during DRAIN → all outputs 0 the next cycle, state IDLE, no redirect issued.
